i2c_init_seq: RTL and testbench
===============================

I2C_INIT_SEQ -- requirements
Module: i2c_init_seq

Interface
REQ-001 Parameter NUM_ENTRIES, default 16, SHALL set the number of table entries to play (1..256).
REQ-002 Parameter MAX_RETRY, default 3, SHALL set the number of retries per entry after a NACK (0..15).
REQ-003 Parameter RETRY_GAP, default 1000, SHALL set the idle CLK cycles between a NACK and its retry (1..2^20).
REQ-004 CLK  in  1  single clock; all state updates on its rising edge.
REQ-005 RESET_N  in  1  asynchronous, active-low reset.
REQ-006 GO  in  1  rising edge while idle starts playback of the table.
REQ-007 TBL_ADDR  out  8  table index being read.
REQ-008 TBL_DATA  in  24  table entry {dev_addr, reg, value}, valid exactly one cycle after TBL_ADDR changes.
REQ-009 I2C_START  out  1  transaction request to the I2C master; the master acts on its rising edge.
REQ-010 I2C_DATA  out  24  entry for the I2C master; held stable while I2C_START is high and until I2C_END returns high.
REQ-011 I2C_END  in  1  master idle flag; low while a transaction runs.
REQ-012 I2C_ACK  in  1  master result; 1 means a NACK was seen; valid when I2C_END is high.
REQ-013 BUSY  out  1  playback in progress.
REQ-014 DONE  out  1  sticky flag set when every entry completed with ACK.
REQ-015 ERROR  out  1  sticky flag set when an entry exhausted its retries.
REQ-016 ERR_INDEX  out  8  index of the failing entry; valid while ERROR is high.

Function
REQ-017 States SHALL be IDLE, FETCH, LATCH, REQ, WAIT_LOW, WAIT_HIGH, CHECK, GAP, FINISH and FAIL.
REQ-018 In IDLE, a GO rising edge SHALL clear DONE, ERROR, the index and the retry counter, set BUSY and enter FETCH.
REQ-019 FETCH SHALL drive TBL_ADDR = index, and LATCH SHALL capture TBL_DATA into I2C_DATA one cycle later.
REQ-020 REQ SHALL raise I2C_START, and WAIT_LOW SHALL hold it high until I2C_END is sampled low, then drop it and enter WAIT_HIGH.
REQ-021 WAIT_HIGH SHALL wait for I2C_END high; CHECK SHALL then sample I2C_ACK in the same cycle.
REQ-022 If ACK=0, CHECK SHALL clear the retry counter; if index = NUM_ENTRIES-1 it enters FINISH, otherwise it increments the index and enters FETCH.
REQ-023 If ACK=1 and retries < MAX_RETRY, CHECK SHALL increment the retry counter and enter GAP.
REQ-024 GAP SHALL last exactly RETRY_GAP cycles and then re-enter REQ for the same entry, with I2C_DATA unchanged.
REQ-025 If ACK=1 and retries = MAX_RETRY, CHECK SHALL set ERROR and ERR_INDEX = index and enter FAIL.
REQ-026 FINISH SHALL set DONE; both FINISH and FAIL SHALL clear BUSY and return to IDLE on the next cycle.
REQ-027 A GO edge while BUSY SHALL be ignored, and GO held high SHALL not retrigger playback.
REQ-028 I2C_START SHALL never be high for fewer than 2 cycles, and SHALL be low for at least 1 cycle between requests.

Reset
REQ-029 Assertion of RESET_N SHALL immediately force the state to IDLE, and mid-transaction it SHALL abandon the transaction.
REQ-030 While in reset: I2C_START=0, I2C_DATA=0, TBL_ADDR=0, BUSY=0, DONE=0, ERROR=0, ERR_INDEX=0, and the counters are zero.
REQ-031 The GO edge detector SHALL reset to "previous high", so GO held high through reset release does not start playback.

Configuration
REQ-032 With I2C_SEQ_DELAY_EN defined, an entry whose dev_addr = 8'hFF SHALL issue no I2C request and SHALL wait {reg,value}*256 CLK cycles, then advance as if ACKed.
REQ-033 Without I2C_SEQ_DELAY_EN, dev_addr 8'hFF SHALL be sent as an ordinary transaction, and no delay counter SHALL be synthesised.

Structure
REQ-034 The shared package i2c_seq_pkg SHALL hold the state enumeration, the DELAY_DEV = 8'hFF constant and the entry field slice positions.
REQ-035 The block SHALL instantiate one sub-module, seq_timer, a loadable down-counter shared by GAP and the delay feature.

Verification
REQ-036 NUM_ENTRIES=3 with a master model that always ACKs, then GO pulse -> three START pulses carrying entries 0,1,2 in order, then DONE=1, BUSY=0, ERROR=0.
REQ-037 Entry 1 NACKs twice then ACKs, MAX_RETRY=3, RETRY_GAP=10 -> entry 1 sent 3 times, each retry at least 10 cycles apart, then DONE=1.
REQ-038 Entry 2 always NACKs, MAX_RETRY=2 -> entry 2 sent 3 times, then ERROR=1, ERR_INDEX=2, DONE=0, and entry 3 never requested.
REQ-039 RESET_N low during WAIT_HIGH of entry 1 -> all outputs zero immediately, and a later GO restarts playback from entry 0.
REQ-040 With I2C_SEQ_DELAY_EN defined and entry 24'hFF0004 -> no START issued, and the next START comes at least 1024 cycles later.
REQ-041 GO pulsed again while BUSY -> no effect, and the transaction sequence is identical to a single GO.

Source files
------------

// File: rtl/i2c_seq_pkg.sv
// Shared types and constants for the I2C init sequencer.
// Holds the FSM state enum, the delay pseudo-device and entry field slices.
package i2c_seq_pkg;

   typedef enum logic [3:0] {
      IDLE,
      FETCH,
      LATCH,
      REQ,
      WAIT_LOW,
      WAIT_HIGH,
      CHECK,
      GAP,
      FINISH,
      FAIL
   } seq_state_t;

   localparam logic [7:0] DELAY_DEV = 8'hFF;

   localparam int ENTRY_W = 24;
   localparam int FLD_W   = 8;
   localparam int DEV_LSB = 16;
   localparam int REG_LSB = 8;
   localparam int VAL_LSB = 0;

   function automatic logic [7:0] entry_dev(
      input logic [ENTRY_W-1:0] e
   );
      return e[DEV_LSB +: FLD_W];
   endfunction

   function automatic logic [15:0] entry_delay(
      input logic [ENTRY_W-1:0] e
   );
      return {e[REG_LSB +: FLD_W], e[VAL_LSB +: FLD_W]};
   endfunction

endpackage

// File: rtl/seq_timer.sv
// Loadable down-counter; o_expired is high while the count is 0 or 1.
// Ports: i_clk, i_reset_n, i_load, i_value (load value), o_expired.
module seq_timer #(
   parameter int W = 21
) (
   input  logic         i_clk,
   input  logic         i_reset_n,
   input  logic         i_load,
   input  logic [W-1:0] i_value,
   output logic         o_expired
);

   logic [W-1:0] r_cnt;

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_value;
      end else if (r_cnt != '0) begin
         r_cnt <= r_cnt - W'(1);
      end
   end

   // A load of N therefore spans exactly N cycles of the waiting state.
   assign o_expired = (r_cnt <= W'(1));

endmodule

// File: rtl/i2c_init_seq.sv
// Plays a table of {dev,reg,value} entries to an I2C master, with NACK retry.
// Ports: i_clk, i_reset_n, i_go, table i/f (o_tbl_addr, i_tbl_data),
// master i/f (o_i2c_start, o_i2c_data, i_i2c_end, i_i2c_ack),
// status (o_busy, o_done, o_error, o_err_index).
// Option I2C_SEQ_DELAY_EN: dev 8'hFF entries become {reg,value}*256 waits.
module i2c_init_seq
   import i2c_seq_pkg::*;
#(
   parameter int unsigned NUM_ENTRIES = 16,
   parameter int unsigned MAX_RETRY   = 3,
   parameter int unsigned RETRY_GAP   = 1000
) (
   input  logic        i_clk,
   input  logic        i_reset_n,
   input  logic        i_go,
   output logic [7:0]  o_tbl_addr,
   input  logic [23:0] i_tbl_data,
   output logic        o_i2c_start,
   output logic [23:0] o_i2c_data,
   input  logic        i_i2c_end,
   input  logic        i_i2c_ack,
   output logic        o_busy,
   output logic        o_done,
   output logic        o_error,
   output logic [7:0]  o_err_index
);

`ifdef I2C_SEQ_DELAY_EN
   localparam int TW = 25;
`else
   localparam int TW = $clog2(RETRY_GAP + 1);
`endif

   seq_state_t r_state, w_state_n;

   logic [7:0]    r_idx, w_idx_n;
   logic [3:0]    r_retry, w_retry_n;
   logic [23:0]   r_data, w_data_n;
   logic          r_busy, w_busy_n;
   logic          r_done, w_done_n;
   logic          r_error, w_error_n;
   logic [7:0]    r_eidx, w_eidx_n;
   logic          r_start, w_start_n;
   logic          r_go_q;
   logic          w_go_rise;
   logic          w_nack;
   logic          w_ld;
   logic [TW-1:0] w_ld_val;
   logic          w_tmr_exp;

`ifdef I2C_SEQ_DELAY_EN
   logic          r_dly, w_dly_n;
   assign w_nack = i_i2c_ack & ~r_dly;
`else
   assign w_nack = i_i2c_ack;
`endif

   assign w_go_rise = i_go & ~r_go_q;

   seq_timer #(
      .W (TW)
   ) u_timer (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .i_load    (w_ld),
      .i_value   (w_ld_val),
      .o_expired (w_tmr_exp)
   );

   always_comb begin
      w_state_n = r_state;
      w_idx_n   = r_idx;
      w_retry_n = r_retry;
      w_data_n  = r_data;
      w_busy_n  = r_busy;
      w_done_n  = r_done;
      w_error_n = r_error;
      w_eidx_n  = r_eidx;
      w_ld      = 1'b0;
      w_ld_val  = '0;
`ifdef I2C_SEQ_DELAY_EN
      w_dly_n   = r_dly;
`endif
      unique case (r_state)
         IDLE: begin
            if (w_go_rise) begin
               w_done_n  = 1'b0;
               w_error_n = 1'b0;
               w_eidx_n  = 8'd0;
               w_idx_n   = 8'd0;
               w_retry_n = 4'd0;
               w_busy_n  = 1'b1;
               w_state_n = FETCH;
            end
         end
         FETCH: w_state_n = LATCH;
         LATCH: begin
            w_data_n  = i_tbl_data;
            w_state_n = REQ;
`ifdef I2C_SEQ_DELAY_EN
            if (entry_dev(i_tbl_data) == DELAY_DEV) begin
               w_ld      = 1'b1;
               w_ld_val  = TW'({entry_delay(i_tbl_data), 8'h00});
               w_dly_n   = 1'b1;
               w_state_n = GAP;
            end
`endif
         end
         REQ: w_state_n = WAIT_LOW;
         WAIT_LOW: begin
            if (!i_i2c_end) w_state_n = WAIT_HIGH;
         end
         WAIT_HIGH: begin
            if (i_i2c_end) w_state_n = CHECK;
         end
         CHECK: begin
            if (!w_nack) begin
               w_retry_n = 4'd0;
`ifdef I2C_SEQ_DELAY_EN
               w_dly_n   = 1'b0;
`endif
               if (r_idx == 8'(NUM_ENTRIES - 1)) begin
                  w_state_n = FINISH;
               end else begin
                  w_idx_n   = r_idx + 8'd1;
                  w_state_n = FETCH;
               end
            end else if (r_retry < 4'(MAX_RETRY)) begin
               w_retry_n = r_retry + 4'd1;
               w_ld      = 1'b1;
               w_ld_val  = TW'(RETRY_GAP);
               w_state_n = GAP;
            end else begin
               w_error_n = 1'b1;
               w_eidx_n  = r_idx;
               w_state_n = FAIL;
            end
         end
         GAP: begin
            if (w_tmr_exp) begin
`ifdef I2C_SEQ_DELAY_EN
               w_state_n = r_dly ? CHECK : REQ;
`else
               w_state_n = REQ;
`endif
            end
         end
         FINISH: begin
            w_done_n  = 1'b1;
            w_busy_n  = 1'b0;
            w_state_n = IDLE;
         end
         FAIL: begin
            w_busy_n  = 1'b0;
            w_state_n = IDLE;
         end
         default: w_state_n = IDLE;
      endcase
      // Registered start: high for REQ plus at least one WAIT_LOW cycle.
      w_start_n = (w_state_n == REQ) || (w_state_n == WAIT_LOW);
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state <= IDLE;
         r_idx   <= 8'd0;
         r_retry <= 4'd0;
         r_data  <= 24'd0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_error <= 1'b0;
         r_eidx  <= 8'd0;
         r_start <= 1'b0;
         // Held-high GO through reset release must not look like an edge.
         r_go_q  <= 1'b1;
      end else begin
         r_state <= w_state_n;
         r_idx   <= w_idx_n;
         r_retry <= w_retry_n;
         r_data  <= w_data_n;
         r_busy  <= w_busy_n;
         r_done  <= w_done_n;
         r_error <= w_error_n;
         r_eidx  <= w_eidx_n;
         r_start <= w_start_n;
         r_go_q  <= i_go;
      end
   end

`ifdef I2C_SEQ_DELAY_EN
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) r_dly <= 1'b0;
      else            r_dly <= w_dly_n;
   end
`endif

   assign o_tbl_addr  = r_idx;
   assign o_i2c_start = r_start;
   assign o_i2c_data  = r_data;
   assign o_busy      = r_busy;
   assign o_done      = r_done;
   assign o_error     = r_error;
   assign o_err_index = r_eidx;

endmodule

// File: tb/tb_i2c_init_seq.sv
// Directed bench for i2c_init_seq with a table model and an I2C master model.
// DUT built with NUM_ENTRIES=4, MAX_RETRY=2, RETRY_GAP=10.
module tb_i2c_init_seq;

   logic        clk = 1'b0;
   logic        rst_n, go, m_end, m_ack, m_clr;
   logic [7:0]  tbl_addr, err_index;
   logic [23:0] tbl_data, i2c_data;
   logic        start, busy, done, error;

   logic [23:0] tbl  [0:3];
   int          plan [0:3];
   int          sent [0:3];
   logic [23:0] log_data [0:31];
   int          log_cyc  [0:31];
   int          n_log;
   int          cyc = 0;
   int          hi_run, min_hi;
   logic        start_q;
   int          busy_cnt;
   int          n_chk = 0;
   int          n_fail = 0;

   always #5 clk = ~clk;

   i2c_init_seq #(
      .NUM_ENTRIES (4),
      .MAX_RETRY   (2),
      .RETRY_GAP   (10)
   ) dut (
      .i_clk       (clk),
      .i_reset_n   (rst_n),
      .i_go        (go),
      .o_tbl_addr  (tbl_addr),
      .i_tbl_data  (tbl_data),
      .o_i2c_start (start),
      .o_i2c_data  (i2c_data),
      .i_i2c_end   (m_end),
      .i_i2c_ack   (m_ack),
      .o_busy      (busy),
      .o_done      (done),
      .o_error     (error),
      .o_err_index (err_index)
   );

   // Synchronous table: data for an address appears one cycle later.
   always @(posedge clk)
      tbl_data <= (tbl_addr < 8'd4) ? tbl[tbl_addr[1:0]] : 24'h0;

   function automatic int find_idx(input logic [23:0] d);
      for (int k = 0; k < 4; k++)
         if (tbl[k] == d) return k;
      return 0;
   endfunction

   // Master: END low for 3 cycles after a START rise; NACK per plan.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_end    <= 1'b1;
         m_ack    <= 1'b0;
         start_q  <= 1'b0;
         busy_cnt <= 0;
      end else begin
         start_q <= start;
         if (start && !start_q) begin
            m_end    <= 1'b0;
            busy_cnt <= 3;
            m_ack    <= (sent[find_idx(i2c_data)] < plan[find_idx(i2c_data)]);
         end else if (busy_cnt > 0) begin
            busy_cnt <= busy_cnt - 1;
            if (busy_cnt == 1) m_end <= 1'b1;
         end
      end
   end

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (m_clr) begin
         n_log  <= 0;
         min_hi <= 99;
         hi_run <= 0;
         for (int k = 0; k < 4; k++) sent[k] <= 0;
      end else begin
         if (start && !start_q && n_log < 32) begin
            log_data[n_log] <= i2c_data;
            log_cyc[n_log]  <= cyc;
            n_log <= n_log + 1;
            sent[find_idx(i2c_data)] <= sent[find_idx(i2c_data)] + 1;
         end
         if (start) begin
            hi_run <= hi_run + 1;
         end else begin
            if (hi_run > 0 && hi_run < min_hi) min_hi <= hi_run;
            hi_run <= 0;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic clr_master();
      @(negedge clk) m_clr = 1'b1;
      @(negedge clk) m_clr = 1'b0;
   endtask

   task automatic pulse_go();
      @(negedge clk) go = 1'b1;
      @(negedge clk) go = 1'b0;
   endtask

   task automatic wait_end(input string tag);
      int n = 0;
      while (!(done || error) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      chk(tag, 32'(done | error), 1);
      repeat (2) @(negedge clk);
   endtask

   task automatic chk_seq(input string tag, input int exp_n,
                          input int e0, input int e1, input int e2,
                          input int e3, input int e4, input int e5);
      int ex [0:5];
      ex = '{e0, e1, e2, e3, e4, e5};
      chk({tag, "_count"}, n_log, exp_n);
      for (int i = 0; i < exp_n && i < 6; i++)
         chk($sformatf("%s_tx%0d", tag, i), log_data[i], tbl[ex[i]]);
   endtask

   initial begin
      rst_n = 1'b0;
      go    = 1'b1;
      m_clr = 1'b0;
      for (int k = 0; k < 4; k++) begin
         tbl[k]  = {8'h42, 8'h10 + 8'(k), 8'hA0 + 8'(k)};
         plan[k] = 0;
      end
      repeat (3) @(negedge clk);
      chk("rst_start", start, 0);
      chk("rst_data", i2c_data, 0);
      chk("rst_addr", tbl_addr, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_error", error, 0);
      chk("rst_eidx", err_index, 0);
      clr_master();
      @(negedge clk) rst_n = 1'b1;
      repeat (5) @(negedge clk);
      chk("go_held_busy", busy, 0);
      chk("go_held_req", n_log, 0);
      go = 1'b0;
      @(negedge clk);

      // All entries ACK.
      pulse_go();
      wait_end("s1_end");
      chk_seq("s1", 4, 0, 1, 2, 3, 0, 0);
      chk("s1_spacing", log_cyc[1] - log_cyc[0], 8);
      chk("s1_done", done, 1);
      chk("s1_busy", busy, 0);
      chk("s1_error", error, 0);
      chk("s1_min_hi", min_hi, 2);

      // Extra GO pulses while busy are ignored.
      clr_master();
      pulse_go();
      repeat (8) @(negedge clk);
      chk("s1b_busy_mid", busy, 1);
      pulse_go();
      repeat (8) @(negedge clk);
      pulse_go();
      wait_end("s1b_end");
      chk_seq("s1b", 4, 0, 1, 2, 3, 0, 0);
      chk("s1b_done", done, 1);

      // Entry 1 NACKs twice then ACKs.
      plan[1] = 2;
      clr_master();
      pulse_go();
      wait_end("s2_end");
      chk_seq("s2", 6, 0, 1, 1, 1, 2, 3);
      chk("s2_gap1", log_cyc[2] - log_cyc[1], 16);
      chk("s2_gap2", log_cyc[3] - log_cyc[2], 16);
      chk("s2_done", done, 1);
      chk("s2_error", error, 0);

      // Entry 2 always NACKs: retries exhausted.
      plan[1] = 0;
      plan[2] = 255;
      clr_master();
      pulse_go();
      wait_end("s3_end");
      chk_seq("s3", 5, 0, 1, 2, 2, 2, 0);
      chk("s3_error", error, 1);
      chk("s3_eidx", err_index, 2);
      chk("s3_done", done, 0);
      chk("s3_busy", busy, 0);

      // Reset during WAIT_HIGH of entry 1.
      plan[2] = 0;
      clr_master();
      pulse_go();
      begin
         int n = 0;
         while (!(n_log == 2 && !m_end && !start) && n < 200) begin
            @(negedge clk);
            n++;
         end
         chk("s4_reach_wh", 32'(n_log == 2 && !m_end && !start), 1);
      end
      rst_n = 1'b0;
      #1;
      chk("s4_busy", busy, 0);
      chk("s4_data", i2c_data, 0);
      chk("s4_addr", tbl_addr, 0);
      chk("s4_start", start, 0);
      chk("s4_done", done, 0);
      chk("s4_error", error, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      clr_master();
      pulse_go();
      wait_end("s4_end");
      chk_seq("s4", 4, 0, 1, 2, 3, 0, 0);
      chk("s4_redone", done, 1);

      tbl[1] = 24'hFF0004;
`ifdef I2C_SEQ_DELAY_EN
      clr_master();
      pulse_go();
      wait_end("s5_end");
      chk_seq("s5", 3, 0, 2, 3, 0, 0, 0);
      chk("s5_delay", 32'(log_cyc[1] - log_cyc[0] >= 1024), 1);
      chk("s5_done", done, 1);
`else
      clr_master();
      pulse_go();
      wait_end("s5_end");
      chk_seq("s5", 4, 0, 1, 2, 3, 0, 0);
      chk("s5_ffdata", log_data[1], 24'hFF0004);
      chk("s5_done", done, 1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
